// File: rtl/decoder3to8_seq.sv
// Sequential 3-to-8 decoder: queues 3-bit codes and replays each as a one-hot strobe
// held for HOLD cycles, with an idle gap between strobes. Define DEC_ACK_EN for ack-terminated strobes.
module decoder3to8_seq #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       vld,
    input  logic [2:0] code,
`ifdef DEC_ACK_EN
    input  logic       ack,
`endif
    output logic       rdy,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] y_q;
    logic       busy_q;
    logic       done_q;

    logic [2:0] mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;

`ifndef DEC_ACK_EN
    logic [7:0] cnt_q;
`endif

    logic [2:0] head_d;
    logic       push_d;
    logic       pop_d;
    logic       start_d;

    assign rdy = (count_q < 2'd2) && !rst;

    always_comb begin
        head_d  = mem_q[rd_ptr_q];
        push_d  = vld && rdy;
`ifdef DEC_ACK_EN
        pop_d   = (state_q == DRIVE) && en && ack;
`else
        pop_d   = (state_q == DRIVE) && en && (cnt_q == 8'd0);
`endif
        // A strobe may start from IDLE or straight out of the one-cycle GAP.
        start_d = (state_q != DRIVE) && en && (count_q != 2'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            y_q      <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
`ifndef DEC_ACK_EN
            cnt_q    <= 8'd0;
`endif
            // NOTE: the queue storage is not reset; count_q alone marks entries valid.
        end else begin
            if (push_d) begin
                mem_q[wr_ptr_q] <= code;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_d) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_d) - 2'(pop_d);
            done_q  <= 1'b0;

            case (state_q)
                IDLE, GAP: begin
                    if (start_d) begin
                        state_q <= DRIVE;
                        y_q     <= 8'h01 << head_d;
                        busy_q  <= 1'b1;
`ifndef DEC_ACK_EN
                        cnt_q   <= 8'(HOLD - 1);
`endif
                    end else begin
                        state_q <= IDLE;
                        y_q     <= 8'h00;
                        busy_q  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!en) begin
                        y_q <= 8'h00;
                    end else if (pop_d) begin
                        state_q <= GAP;
                        y_q     <= 8'h00;
                        done_q  <= 1'b1;
                    end else begin
                        // Reload from head so a strobe resumes cleanly after an en stall.
                        y_q <= 8'h01 << head_d;
`ifndef DEC_ACK_EN
                        cnt_q <= cnt_q - 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    y_q     <= 8'h00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Self-checking bench for decoder3to8_seq: directed scenarios then random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_decoder3to8_seq;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       vld;
    logic [2:0] code;
    logic       rdy;
    logic [7:0] y;
    logic       busy;
    logic       done;
`ifdef DEC_ACK_EN
    logic       ack;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: queue of pending codes plus the number of strobe cycles delivered.
    int         q[$];
    bit         m_strobing = 1'b0;
    bit         m_gap      = 1'b0;
    int         m_served   = 0;
    logic [7:0] m_y        = 8'h00;
    logic       m_done     = 1'b0;
    bit         m_pushed   = 1'b0;

    always #5 clk = ~clk;

    decoder3to8_seq #(.HOLD(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .vld  (vld),
        .code (code),
`ifdef DEC_ACK_EN
        .ack  (ack),
`endif
        .rdy  (rdy),
        .y    (y),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit can_push;
        bit finish_strobe;
        can_push = (q.size() < 2) && !rst;
        m_pushed = vld && can_push;
        if (rst) begin
            q.delete();
            m_strobing = 1'b0;
            m_gap      = 1'b0;
            m_served   = 0;
            m_y        = 8'h00;
            m_done     = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_strobing) begin
            if (en) begin
`ifdef DEC_ACK_EN
                finish_strobe = ack;
`else
                finish_strobe = (m_served == HOLD);
`endif
                if (finish_strobe) begin
                    void'(q.pop_front());
                    m_y        = 8'h00;
                    m_done     = 1'b1;
                    m_gap      = 1'b1;
                    m_strobing = 1'b0;
                end else begin
                    m_y = 8'(1 << q[0]);
                    m_served++;
                end
            end else begin
                m_y = 8'h00;
            end
        end else begin
            m_gap = 1'b0;
            if (en && q.size() > 0) begin
                m_strobing = 1'b1;
                m_served   = 1;
                m_y        = 8'(1 << q[0]);
            end else begin
                m_y = 8'h00;
            end
        end
        if (m_pushed) q.push_back(int'(code));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        vectors++;
        check("y", y, m_y);
        check("done", 8'(done), 8'(m_done));
        check("busy", 8'(busy), 8'(m_strobing || m_gap));
        check("rdy", 8'(rdy), 8'((q.size() < 2) && !rst));
        check("onehot0", 8'($onehot0(y)), 8'h01);
    endtask

    task automatic push(input logic [2:0] c);
        int waited;
        vld    = 1'b1;
        code   = c;
        waited = 0;
        m_pushed = 1'b0;
        while (!m_pushed && waited < 20) begin
            tick();
            waited++;
        end
        if (!m_pushed) begin
            miscompares++;
            $error("FAIL push_timeout: observed no transfer expected transfer of %0d", c);
        end
        vld = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        vld  = 1'b0;
        code = 3'd0;
`ifdef DEC_ACK_EN
        ack  = 1'b0;
`endif
        // Reset then single code
        tick();
        tick();
        rst = 1'b0;
        push(3'd5);
        repeat (8) tick();

        // Back-to-back burst; the third push waits for the first pop
        push(3'd7);
        push(3'd0);
        push(3'd3);
        repeat (20) tick();

        // Same line twice
        push(3'd2);
        push(3'd2);
        repeat (12) tick();

        // Enable stall after the second strobe cycle
        push(3'd1);
        tick();
        tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (6) tick();

        // Reset mid-strobe during the third cycle of 8'h10
        push(3'd4);
        push(3'd6);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();

`ifdef DEC_ACK_EN
        // Ack-terminated strobe
        push(3'd3);
        repeat (10) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (4) tick();
`endif

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            vld  = 1'($urandom_range(0, 1));
            code = 3'($urandom_range(0, 7));
            en   = ($urandom_range(0, 7) != 0);
            rst  = ($urandom_range(0, 99) == 0);
`ifdef DEC_ACK_EN
            ack  = ($urandom_range(0, 5) == 0);
`endif
            tick();
        end
        rst = 1'b0;
        vld = 1'b0;
        en  = 1'b1;
`ifdef DEC_ACK_EN
        ack = 1'b1;
`endif
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
